// File: rtl/comm_sched_pkg.sv
// comm_sched_pkg: shared constants, FSM states and select-code helper for commutator_sched
package comm_sched_pkg;
    localparam int N_IN  = 8;
    localparam int N_CH  = 3;
    localparam int SEL_W = 3;

    typedef enum logic [2:0] {IDLE, SNAP, SETUP, STROBE, HOLD, DWELL} state_t;

    // The commutator mux decodes its select bus bit-reversed
    function automatic logic [SEL_W-1:0] bitrev3(input logic [SEL_W-1:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction
endpackage

// File: rtl/commutator_sched_rr_pick.sv
// rr_pick: index of the first set mask bit at or above start, wrapping past the top source
module rr_pick
    import comm_sched_pkg::*;
(
    input  logic [N_IN-1:0]  mask,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);
    // Scan farthest-first so the hit nearest to start is the one that sticks
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (mask[start + SEL_W'(i)]) begin
                found = 1'b1;
                idx   = start + SEL_W'(i);
            end
        end
    end
endmodule

// File: rtl/commutator_sched.sv
// commutator_sched: round-robin 8-to-3 commutator scheduler with latch programming and dwell hold
// Define COMM_SCHED_SKIP_UNCHANGED_EN to skip rewriting channels whose source is unchanged
module commutator_sched
    import comm_sched_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [N_IN-1:0]       req,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [SEL_W-1:0]      sel_data,
    output logic [N_CH-1:0]       sel_wr,
    output logic [N_CH-1:0]       grant_valid,
    output logic [N_CH*SEL_W-1:0] grant_src,
    output logic                  busy,
    output logic                  frame_done
);
    state_t             state, state_nxt;
    logic [1:0]         ch;
    logic [N_IN-1:0]    req_snap, taken;
    logic [SEL_W-1:0]   rr_ptr, pick;
    logic [DWELL_W-1:0] cnt, dwell_last;
    logic               found, skip, last_ch, last_dwell;

    rr_pick u_pick (
        .mask (req_snap & ~taken),
        .start(rr_ptr),
        .found(found),
        .idx  (pick)
    );

    assign last_ch    = ch == 2'(N_CH - 1);
    assign dwell_last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign last_dwell = cnt == dwell_last;

`ifdef COMM_SCHED_SKIP_UNCHANGED_EN
    assign skip = found && grant_valid[ch] && grant_src[ch*SEL_W +: SEL_W] == pick;
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = en ? SNAP : IDLE;
            SNAP:    state_nxt = SETUP;
            SETUP:   state_nxt = (found && !skip) ? STROBE : (last_ch ? DWELL : SETUP);
            STROBE:  state_nxt = HOLD;
            HOLD:    state_nxt = last_ch ? DWELL : SETUP;
            DWELL:   state_nxt = last_dwell ? (en ? SNAP : IDLE) : DWELL;
            default: state_nxt = IDLE;
        endcase
    end

    // Select code stays on the bus across SETUP/STROBE/HOLD since pick only moves after HOLD
    always_comb begin
        busy       = state != IDLE;
        sel_wr     = (state == STROBE) ? N_CH'(1) << ch : '0;
        sel_data   = (found && (state == SETUP || state == STROBE || state == HOLD)) ? bitrev3(pick) : '0;
        frame_done = state == DWELL && last_dwell;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch          <= '0;
            req_snap    <= '0;
            taken       <= '0;
            rr_ptr      <= '0;
            cnt         <= '0;
            grant_valid <= '0;
            grant_src   <= '0;
        end else begin
            cnt <= (state == DWELL && !last_dwell) ? cnt + DWELL_W'(1) : '0;
            if (state == SNAP) begin
                req_snap <= req;
                taken    <= '0;
                ch       <= '0;
            end
            if ((state == SETUP && skip) || state == HOLD) begin
                taken[pick] <= 1'b1;
                rr_ptr      <= pick + SEL_W'(1);
            end
            if (state == HOLD) begin
                grant_valid[ch]              <= 1'b1;
                grant_src[ch*SEL_W +: SEL_W] <= pick;
            end
            if (state == SETUP && !found) grant_valid[ch] <= 1'b0;
            if (((state == SETUP && (!found || skip)) || state == HOLD) && !last_ch) ch <= ch + 2'd1;
        end
    end
endmodule

// File: tb/tb_commutator_sched.sv
// tb_commutator_sched: directed frame table plus randomized frames against a frame-level scheduling model
module tb_commutator_sched;
    typedef struct {
        logic [7:0] rq;
        logic [7:0] dw;
        logic       en_end;
        bit         scr;
        logic [2:0] ev;
        logic [8:0] es;
        int         len;
    } vec_t;

    logic       clk = 0, rst_n = 0, en = 0;
    logic [7:0] req = 0, dwell = 0;
    logic [2:0] sel_data, sel_wr, grant_valid;
    logic [8:0] grant_src;
    logic       busy, frame_done;

    int         total = 0, bad = 0, cyc = 0, fd_at = -1;
    bit         skip_on;
    logic [2:0] m_ptr, m_valid;
    logic [2:0] m_src [3];

    commutator_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req        (req),
        .dwell      (dwell),
        .sel_data   (sel_data),
        .sel_wr     (sel_wr),
        .grant_valid(grant_valid),
        .grant_src  (grant_src),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (!$onehot0(sel_wr)) begin
                bad++;
                $display("FAIL sel_wr_onehot: got %b, at most one bit allowed", sel_wr);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (frame cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic rst_chk(input string nm);
        chk({nm, " sel_data"}, 32'(sel_data), 0);
        chk({nm, " sel_wr"}, 32'(sel_wr), 0);
        chk({nm, " grant_valid"}, 32'(grant_valid), 0);
        chk({nm, " grant_src"}, 32'(grant_src), 0);
        chk({nm, " busy"}, 32'(busy), 0);
        chk({nm, " frame_done"}, 32'(frame_done), 0);
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        for (int c = 0; c < 3; c++) m_src[c] = 0;
    endtask

    function automatic bit skips(input int c, input logic [2:0] p);
        return skip_on && m_valid[c] && m_src[c] == p;
    endfunction

    task automatic cycle_chk(input string nm, input logic bz, input logic [2:0] wr,
                             input logic [2:0] sd, input bit chk_sd, input logic fd);
        @(negedge clk);
        cyc++;
        if (frame_done && fd_at < 0) fd_at = cyc;
        chk({nm, " busy"}, 32'(busy), 32'(bz));
        chk({nm, " sel_wr"}, 32'(sel_wr), 32'(wr));
        chk({nm, " frame_done"}, 32'(frame_done), 32'(fd));
        if (chk_sd) chk({nm, " sel_data"}, 32'(sel_data), 32'(sd));
        chk({nm, " grant_valid"}, 32'(grant_valid), 32'(m_valid));
        chk({nm, " grant_src"}, 32'(grant_src), 32'({m_src[2], m_src[1], m_src[0]}));
    endtask

    task automatic idle_cycle(input logic en_v);
        cycle_chk("idle", 0, 0, 0, 0, 0);
        en = en_v;
    endtask

    // Walks one frame from SNAP to the last dwell cycle; grants derive from round-robin over the snapshot
    task automatic frame(input logic [7:0] rq, input logic [7:0] dw, input logic en_end, input bit scr);
        logic [7:0] tk;
        logic [2:0] p;
        bit         f;
        int         n, d;
        cyc   = 0;
        fd_at = -1;
        cycle_chk("snap", 1, 0, 0, 0, 0);
        req   = rq;
        dwell = dw;
        tk    = 0;
        for (int c = 0; c < 3; c++) begin
            f = 0;
            p = 0;
            for (int i = 0; i < 8 && !f; i++) begin
                n = (int'(m_ptr) + i) % 8;
                if (rq[n] && !tk[n]) begin
                    f = 1;
                    p = 3'(n);
                end
            end
            if (!f) begin
                cycle_chk("empty", 1, 0, 0, 0, 0);
                m_valid[c] = 0;
            end else begin
                n = skips(c, p) ? 1 : 3;
                for (int s = 0; s < n; s++) begin
                    cycle_chk("write", 1, (n == 3 && s == 1) ? 3'(1 << c) : 3'd0, {p[0], p[1], p[2]}, n == 3, 0);
                    if (scr) req = 8'($urandom);
                end
                tk[p]      = 1;
                m_src[c]   = p;
                m_valid[c] = 1;
                m_ptr      = p + 3'd1;
            end
            if (scr) req = 8'($urandom);
        end
        en = en_end;
        d  = (dw == 0) ? 1 : int'(dw);
        for (int j = 0; j < d; j++) cycle_chk("dwell", 1, 0, 0, 0, j == d - 1);
    endtask

    initial begin
        vec_t tbl[7];
        int   e;
`ifdef COMM_SCHED_SKIP_UNCHANGED_EN
        skip_on = 1;
`else
        skip_on = 0;
`endif
        tbl[0] = '{8'h82, 8'd4, 1'b1, 1'b1, 3'b011, 9'o071, 12};
        tbl[1] = '{8'hFF, 8'd2, 1'b1, 1'b1, 3'b111, 9'o210, 12};
        tbl[2] = '{8'hFF, 8'd1, 1'b1, 1'b0, 3'b111, 9'o543, 11};
        tbl[3] = '{8'hFF, 8'd3, 1'b0, 1'b1, 3'b111, 9'o076, 13};
        tbl[4] = '{8'h40, 8'd0, 1'b1, 1'b0, 3'b001, 9'o076, skip_on ? 5 : 7};
        tbl[5] = '{8'h01, 8'd2, 1'b1, 1'b0, 3'b001, 9'o070, 8};
        tbl[6] = '{8'h01, 8'd2, 1'b0, 1'b1, 3'b001, 9'o070, skip_on ? 6 : 8};

        model_reset();
        repeat (2) @(negedge clk);
        rst_chk("reset");
        rst_n = 1;
        idle_cycle(1);
        for (int k = 0; k < 7; k++) begin
            frame(tbl[k].rq, tbl[k].dw, tbl[k].en_end, tbl[k].scr);
            chk("frame_len", 32'(fd_at), 32'(tbl[k].len));
            chk("grant_valid_end", 32'(grant_valid), 32'(tbl[k].ev));
            chk("grant_src_end", 32'(grant_src), 32'(tbl[k].es));
            if (!tbl[k].en_end) begin
                idle_cycle(0);
                idle_cycle(1);
            end
        end

        // Reset asserted while channel 0 strobes; outputs must drop before the next edge
        @(negedge clk);
        req = 8'h02;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_strobe", 32'(sel_wr), 32'b001);
        rst_n = 0;
        #1;
        rst_chk("async_reset");
        repeat (2) @(negedge clk);
        rst_chk("reset_hold");
        en    = 0;
        rst_n = 1;
        model_reset();
        idle_cycle(0);
        idle_cycle(1);

        for (int n = 0; n < 40; n++) begin
            e = $urandom_range(0, 3);
            frame(8'($urandom), 8'($urandom_range(0, 5)), e != 0, 1'b1);
            if (e == 0) begin
                idle_cycle(0);
                idle_cycle(1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
